// File: rtl/core_pkg.sv
// core_pkg: shared RV32 core constants and the fetch FSM state type
package core_pkg;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic {S_BOOT, S_RUN} fetch_state_t;
endpackage

// File: rtl/fetch_jal_target.sv
// fetch_jal_target: JAL target = pc + sign-extended J-immediate (only the immediate bits are needed)
module fetch_jal_target (
  input  logic [31:0]  pc,
  input  logic [31:12] instr_hi,
  output logic [31:0]  target
);
  assign target = pc + {{12{instr_hi[31]}}, instr_hi[19:12], instr_hi[20], instr_hi[30:21], 1'b0};
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC + BRAM fetch + IF/ID register; JAL prediction under FETCH_JAL_PREDICT_EN
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rstn,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc,
  output logic               if_pred_taken
);
  fetch_state_t state_q, state_d;
  logic [31:0] fpc_q, fpc_d, if_instr_q, if_instr_d, if_pc_q, if_pc_d, addr_pc, nextpc;
  logic fvalid_q, fvalid_d, if_valid_q, if_valid_d, if_pred_q, if_pred_d, jal_hit;
`ifdef FETCH_JAL_PREDICT_EN
  logic [31:0] jal_tgt;
  fetch_jal_target u_jal (.pc(fpc_q), .instr_hi(imem_rdata[31:12]), .target(jal_tgt));
  assign jal_hit = fvalid_q && imem_rdata[6:0] == OPC_JAL;
  assign nextpc  = jal_hit ? jal_tgt : fpc_q + 32'd4;
`else
  assign jal_hit = 1'b0;
  assign nextpc  = fpc_q + 32'd4;
`endif
  // next fetch PC and IF/ID contents; redirect beats stall beats advance
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    fvalid_d   = fvalid_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_pred_d  = if_pred_q;
    addr_pc    = fpc_q;
    if (state_q == S_BOOT) begin
      addr_pc  = redirect ? redirect_pc : RESET_PC;
      fpc_d    = addr_pc;
      fvalid_d = 1'b1;
      state_d  = S_RUN;
    end else if (redirect) begin
      addr_pc    = redirect_pc;
      fpc_d      = redirect_pc;
      fvalid_d   = 1'b1;
      if_valid_d = 1'b0;
      if_pred_d  = 1'b0;
    end else if (!stall) begin
      if_valid_d = fvalid_q;
      if_instr_d = imem_rdata;
      if_pc_d    = fpc_q;
      if_pred_d  = jal_hit;
      addr_pc    = nextpc;
      fpc_d      = nextpc;
    end
  end
  // state, fetch PC and IF/ID registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_BOOT;
      fpc_q      <= RESET_PC;
      fvalid_q   <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
      if_pred_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      fvalid_q   <= fvalid_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_pred_q  <= if_pred_d;
    end
  end
  assign imem_addr     = rstn ? addr_pc[IMEM_AW+1:2] : RESET_PC[IMEM_AW+1:2];
  assign if_valid      = if_valid_q;
  assign if_instr      = if_instr_q;
  assign if_pc         = if_pc_q;
  assign if_pred_taken = if_pred_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed + random stimulus against an instruction-stream reference model
module tb_fetch_stage;
  localparam logic [31:0] RST = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_JAL_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif
  logic clk, rstn, stall, redirect, if_valid, if_pred_taken;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata, redirect_pc, if_instr, if_pc;
  logic [31:0] mem [0:16383];
  int n_pass = 0, n_chk = 0;
  logic m_boot = 1'b1, m_valid = 1'b0, m_pt = 1'b0;
  logic [31:0] m_next = RST, m_pc = 32'h0, m_instr = NOP;

  fetch_stage #(.RESET_PC(RST), .IMEM_AW(14)) dut (
    .clk(clk), .rstn(rstn), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pred_taken(if_pred_taken)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  function automatic logic [31:0] jimm(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    logic [31:0] ins;
    logic jal;
    rstn = r; stall = s; redirect = rd; redirect_pc = rpc;
    #1;
    if (!r) begin
      m_boot = 1'b1; m_next = RST; m_valid = 1'b0; m_instr = NOP; m_pc = 32'h0; m_pt = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_next = rd ? rpc : RST;
    end else if (rd) begin
      m_next = rpc; m_valid = 1'b0; m_pt = 1'b0;
    end else if (!s) begin
      ins = mem[m_next[15:2]];
      jal = PRED && ins[6:0] == 7'b1101111;
      m_valid = 1'b1; m_pc = m_next; m_instr = ins; m_pt = jal;
      m_next = m_next + (jal ? jimm(ins) : 32'd4);
    end
    chk("imem_addr", 32'(imem_addr), 32'(m_next[15:2]));
    @(posedge clk);
    #1;
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_pc);
    chk("if_pred_taken", 32'(if_pred_taken), 32'(m_pt));
  endtask

  initial begin
    logic [31:0] w;
    clk = 1'b0; rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 16384; i++) begin
      w = $urandom;
      if (w[6:0] == 7'b1101111) w[4] = 1'b0;
      mem[i] = w;
    end
    mem[14'h80] = 32'h0400_006F;
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_instr", if_instr, NOP);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("boot_bubble", 32'(if_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("boot_valid", 32'(if_valid), 32'd1);
    chk("boot_pc", if_pc, 32'h100);
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("pre_stall_pc", if_pc, 32'h108);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_hold_pc", if_pc, 32'h108);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("post_stall_pc", if_pc, 32'h10C);
    step(1'b1, 1'b0, 1'b1, 32'h400);
    chk("redir_bubble", 32'(if_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_pc", if_pc, 32'h400);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("redir_next", if_pc, 32'h404);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("jal_pc", if_pc, 32'h200);
    chk("jal_pred", 32'(if_pred_taken), 32'(PRED));
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("jal_succ", if_pc, PRED ? 32'h240 : 32'h204);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst_pulse_valid", 32'(if_valid), 32'd0);
    chk("rst_pulse_nop", if_instr, NOP);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("reboot_pc", if_pc, RST);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", if_pc, 32'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFFC);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 5-stage RV32 core. It holds the fetch PC and drives the synchronous-read instruction BRAM. It presents one instruction per cycle to decode through the IF/ID register, and that decoder splits the instruction into opcode, funct7 and register fields. It also applies downstream stalls and branch/jump redirects, and can optionally predict JAL targets locally.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetched instruction.
- `IMEM_AW`, default 14: instruction BRAM word-address width.

- `clk`  in  1  core clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `imem_addr`  out  IMEM_AW  BRAM word address; the BRAM registers it, so data appears on `imem_rdata` in the next cycle.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  decode cannot accept; hold IF/ID.
- `redirect`  in  1  branch/jump resolved to a new PC (from EX).
- `redirect_pc`  in  32  redirect target.
- `if_valid`  out  1  IF/ID holds a real instruction.
- `if_instr`  out  32  IF/ID instruction.
- `if_pc`  out  32  IF/ID PC.
- `if_pred_taken`  out  1  this instruction's successor was fetched from a predicted target.

## Operation
- Internal state:
  - FSM `S_BOOT`/`S_RUN`.
  - `fpc`: PC of the fetch issued last cycle, whose data is on `imem_rdata` now.
  - `fvalid`: that fetch is live.
- Reset (`rstn`=0 at an edge):
  - state `S_BOOT`, `fvalid`=0, `fpc`=RESET_PC.
  - `if_valid`=0, `if_instr`=32'h0000_0013 (NOP), `if_pc`=0, `if_pred_taken`=0.
  - While `rstn`=0, `imem_addr`=RESET_PC[IMEM_AW+1:2].
- `S_BOOT` (one cycle):
  - `imem_addr`=RESET_PC word.
  - Next: `fpc`=RESET_PC, `fvalid`=1, go to `S_RUN`.
  - `stall` is ignored in this state. `redirect` overrides RESET_PC with `redirect_pc`.
- `S_RUN`, priority redirect > stall > advance:
  - **Redirect.** `imem_addr`=redirect_pc word. Next: `fpc`=redirect_pc, `fvalid`=1, `if_valid`=0, `if_pred_taken`=0. The in-flight fetch is discarded.
  - **Stall.** `imem_addr`=`fpc` word, which re-reads so `imem_rdata` stays stable. `fpc`, `fvalid` and all `if_*` outputs hold.
  - **Advance.** IF/ID ← {`fvalid`, `imem_rdata`, `fpc`}. `nextpc`=`fpc`+4, or the predicted target (see Configuration). `imem_addr`=`nextpc` word. `fpc` ← `nextpc`.
- PC arithmetic is 32-bit modulo 2^32; 0xFFFF_FFFC+4 wraps to 0.
- `imem_addr` is `pc[IMEM_AW+1:2]`. Upper PC bits are ignored, so the address aliases. PC bits [1:0] are assumed 0 and not checked.

## Timing
- Throughput: 1 instruction/cycle when `stall`=0.
- Boot: let B be the first cycle with `rstn`=1. RESET_PC appears on `if_*` with `if_valid`=1 in cycle B+2.
- Redirect latency: `redirect` in cycle r gives `if_valid`=0 in r+1, and the target instruction is on `if_*` in r+2. This is a one-bubble penalty.
- Stall has a combinational effect on `imem_addr` in the same cycle and a registered effect on `if_*`.
- `if_*` outputs come straight from registers, with no combinational path from inputs.
- Reset mid-stall or mid-redirect: reset wins unconditionally and the sequence restarts from `S_BOOT`.

## Configuration
- `FETCH_JAL_PREDICT_EN` defined:
  - On advance, if `fvalid` and `imem_rdata[6:0]`=7'b1101111 (JAL), then `nextpc`=`fpc`+J-imm and the captured `if_pred_taken`=1.
  - J-imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}.
  - EX must suppress its redirect for a JAL with `if_pred_taken`=1.
- Macro undefined: `nextpc` is always `fpc`+4 and `if_pred_taken` is a constant 0.

## Structure
- Shared package (`core_pkg`) holds:
  - opcode constant `OPC_JAL`=7'b1101111
  - `NOP_INSTR`=32'h0000_0013
  - FSM state enum `fetch_state_t`
- Sub-module `fetch_jal_target` holds the J-imm extraction and target adder. It is instantiated only under `FETCH_JAL_PREDICT_EN`.

## Test plan
- RESET_PC=0x100, release `rstn`, no stall → `if_valid` first 1 at B+2 with `if_pc`=0x100, then 0x104 and 0x108 on consecutive cycles; `imem_addr` sequence 0x40, 0x41, 0x42.
- `stall`=1 for 3 cycles while `if_pc`=0x108 → all `if_*` and `imem_addr` constant; the cycle after release gives `if_pc`=0x10C.
- `redirect`=1, `redirect_pc`=0x400 in cycle r → `if_valid`=0 in r+1; `if_pc`=0x400 and `if_valid`=1 in r+2; 0x404 in r+3.
- `redirect` and `stall` both asserted in the same cycle → redirect wins; `if_pc`=target two cycles later.
- Instruction 0x0400006F (JAL x0,+0x40) at 0x200 → with macro: next `if_pc`=0x240 and JAL's `if_pred_taken`=1; without macro: next `if_pc`=0x204 and `if_pred_taken`=0.
- `rstn` pulsed low for one cycle during a stall → `if_valid`=0 the next cycle, `if_instr`=NOP, and fetch restarts at RESET_PC per the boot timing.
